// File: rtl/board_pkg.sv
// Shared widths, board geometry, tile codes and FSM encoding for the board RAM arbiter.
package board_pkg;

  localparam int unsigned X_W     = 6;
  localparam int unsigned Y_W     = 6;
  localparam int unsigned D_W     = 3;
  localparam int unsigned A_W     = X_W + Y_W;
  localparam int unsigned BOARD_W = 40;
  localparam int unsigned BOARD_H = 30;

  localparam logic [D_W-1:0] TILE_EMPTY  = 3'd0;
  localparam logic [D_W-1:0] TILE_PELLET = 3'd1;
  localparam logic [D_W-1:0] TILE_POWER  = 3'd2;
  localparam logic [D_W-1:0] TILE_WALL   = 3'd3;
  localparam logic [D_W-1:0] TILE_DOOR   = 3'd4;

  localparam logic [D_W-1:0] INIT_TILE = TILE_PELLET;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt_c
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_c = 2'b00;
    ptr_d = ptr_q;
    if (en) begin
      unique case (req)
        2'b01:   gnt_c = 2'b01;
        2'b10:   gnt_c = 2'b10;
        2'b11:   gnt_c = ptr_q ? 2'b10 : 2'b01;
        default: gnt_c = 2'b00;
      endcase
    end
    // After a grant, favour the other requester next time.
    if (gnt_c != 2'b00) begin
      ptr_d = gnt_c[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/board_mem_arbiter.sv
// Single-port board RAM shared by the VGA renderer and two game requesters,
// after a power-up sweep that fills every address with the initial tile.
module board_mem_arbiter #(
  parameter int unsigned     X_W       = board_pkg::X_W,
  parameter int unsigned     Y_W       = board_pkg::Y_W,
  parameter int unsigned     D_W       = board_pkg::D_W,
  parameter int unsigned     BOARD_W   = board_pkg::BOARD_W,
  parameter int unsigned     BOARD_H   = board_pkg::BOARD_H,
  parameter logic [D_W-1:0]  INIT_TILE = D_W'(board_pkg::INIT_TILE)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [X_W-1:0]             vga_x,
  input  logic [Y_W-1:0]             vga_y,
  output logic [D_W-1:0]             vga_data,
  input  logic [1:0]                 req_valid,
  input  logic [1:0]                 req_we,
  input  logic [2*(X_W+Y_W)-1:0]     req_addr,
  input  logic [2*D_W-1:0]           req_wdata,
  output logic [1:0]                 req_ready,
  output logic [1:0]                 rsp_valid,
  output logic [D_W-1:0]             rsp_data,
  output logic [X_W+Y_W-1:0]         mem_addr,
  output logic                       mem_we,
  output logic [D_W-1:0]             mem_wdata,
  input  logic [D_W-1:0]             mem_rdata,
  output logic                       init_done
);

  import board_pkg::state_e;
  import board_pkg::ST_INIT;
  import board_pkg::ST_RUN;

  localparam int unsigned    A_W      = X_W + Y_W;
  localparam logic [A_W-1:0] CNT_LAST = '1;

  function automatic logic in_board(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (32'(x) < BOARD_W) && (32'(y) < BOARD_H);
  endfunction

  state_e         state_q,     state_d;
  logic [A_W-1:0] cnt_q,       cnt_d;
  logic           phase_q,     phase_d;
  logic           vga_pend_q,  vga_pend_d;
  logic           vga_oob_q,   vga_oob_d;
  logic [D_W-1:0] vga_data_q,  vga_data_d;
  logic [1:0]     rd_pend_q,   rd_pend_d;
  logic [1:0]     rsp_valid_q, rsp_valid_d;
  logic [D_W-1:0] rsp_data_q,  rsp_data_d;
  logic           init_done_q, init_done_d;

  logic           arb_en_c;
  logic [1:0]     gnt_c;
  logic [A_W-1:0] sel_addr_c;
  logic           sel_we_c;
  logic [D_W-1:0] sel_wdata_c;
  logic           sel_in_board_c;

  assign arb_en_c = (state_q == ST_RUN) && phase_q;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en_c),
    .req   (req_valid),
    .gnt_c (gnt_c)
  );

  // Payload of whichever requester owns the game slot.
  assign sel_addr_c     = gnt_c[1] ? req_addr[2*A_W-1:A_W] : req_addr[A_W-1:0];
  assign sel_we_c       = gnt_c[1] ? req_we[1] : req_we[0];
  assign sel_wdata_c    = gnt_c[1] ? req_wdata[2*D_W-1:D_W] : req_wdata[D_W-1:0];
  assign sel_in_board_c = in_board(sel_addr_c[X_W-1:0], sel_addr_c[A_W-1:X_W]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    vga_pend_d  = 1'b0;
    vga_oob_d   = 1'b0;
    vga_data_d  = vga_data_q;
    rd_pend_d   = 2'b00;
    rsp_valid_d = 2'b00;
    rsp_data_d  = '0;
    init_done_d = init_done_q;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    req_ready   = 2'b00;

    unique case (state_q)
      ST_INIT: begin
        // Strobe is gated by rst_n so nothing is written while reset is held.
        mem_addr   = cnt_q;
        mem_we     = rst_n;
        mem_wdata  = rst_n ? INIT_TILE : '0;
        vga_data_d = '0;
        cnt_d      = cnt_q + A_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          phase_d     = 1'b0;
          init_done_d = 1'b1;
        end
      end

      ST_RUN: begin
        phase_d = ~phase_q;
        // Read data for the previous slot arrives this cycle.
        if (vga_pend_q) begin
          vga_data_d = vga_oob_q ? '0 : mem_rdata;
        end
        if (rd_pend_q != 2'b00) begin
          rsp_valid_d = rd_pend_q;
          rsp_data_d  = mem_rdata;
        end

        if (!phase_q) begin
          mem_addr   = {vga_y, vga_x};
          vga_pend_d = 1'b1;
          vga_oob_d  = !in_board(vga_x, vga_y);
        end else if (gnt_c != 2'b00) begin
          req_ready = gnt_c;
          mem_addr  = sel_addr_c;
          mem_we    = sel_we_c && sel_in_board_c;
          mem_wdata = (sel_we_c && sel_in_board_c) ? sel_wdata_c : '0;
          rd_pend_d = sel_we_c ? 2'b00 : gnt_c;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      vga_pend_q  <= 1'b0;
      vga_oob_q   <= 1'b0;
      vga_data_q  <= '0;
      rd_pend_q   <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      vga_pend_q  <= vga_pend_d;
      vga_oob_q   <= vga_oob_d;
      vga_data_q  <= vga_data_d;
      rd_pend_q   <= rd_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      init_done_q <= init_done_d;
    end
  end

  assign vga_data  = vga_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Bench for board_mem_arbiter: model RAM, shadow board, response scoreboard.
module tb_board_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [5:0]  vga_x, vga_y;
  logic [2:0]  vga_data;
  logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [23:0] req_addr;
  logic [5:0]  req_wdata;
  logic [2:0]  rsp_data;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [2:0]  mem_wdata, mem_rdata;
  logic        init_done;

  board_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .vga_x(vga_x), .vga_y(vga_y), .vga_data(vga_data),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [2:0] ram    [4096];
  logic [2:0] shadow [4096];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    int         due;
    int         idx;
    logic [2:0] data;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [1:0]  v, we;
    logic [11:0] a0, a1;
    logic [2:0]  d0, d1;
    logic [1:0]  rdy;
    logic        mwe;
    logic [11:0] maddr;
    logic [2:0]  mwd;
  } vec_t;
  vec_t tbl[12];

  int n_cmp = 0;
  int n_err = 0;
  int run_cyc = 0;
  bit in_run = 0;
  bit mon_en = 0;

  function automatic logic [11:0] addr_of(input int y, input int x);
    return {6'(y), 6'(x)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (run_cyc %0d)", name, act, exp, run_cyc);
    end
  endtask

  // Advance one clock; during RUN also check the response port against the scoreboard.
  task automatic tick();
    logic [1:0] ev;
    logic [2:0] ed;
    @(posedge clk);
    #2;
    if (in_run) run_cyc++;
    if (mon_en) begin
      ev = 2'b00;
      ed = 3'd0;
      if (sb.size() > 0 && sb[0].due == run_cyc) begin
        ev = (sb[0].idx == 1) ? 2'b10 : 2'b01;
        ed = sb[0].data;
        void'(sb.pop_front());
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("rsp_data", 32'(rsp_data), 32'(ed));
    end
  endtask

  task automatic align(input int ph);
    for (int i = 0; i < 4 && (run_cyc % 2) != ph; i++) tick();
  endtask

  // Entered in the cycle where rst_n has just been released.
  task automatic init_sweep();
    for (int k = 0; k < 4096; k++) begin
      #1;
      n_cmp++;
      if (!(mem_we === 1'b1 && mem_addr === 12'(k) && mem_wdata === 3'd1 &&
            req_ready === 2'b00 && rsp_valid === 2'b00 && init_done === 1'b0)) begin
        n_err++;
        $display("FAIL init_sweep k=%0d: got we=%b addr=%0d wdata=%0d ready=%b rsp=%b done=%b required we=1 addr=%0d wdata=1 ready=00 rsp=00 done=0",
                 k, mem_we, mem_addr, mem_wdata, req_ready, rsp_valid, init_done, k);
      end
      tick();
    end
    in_run  = 1;
    run_cyc = 0;
    #1;
    chk("init_done", 32'(init_done), 32'd1);
    chk("run0_vga_slot_we", 32'(mem_we), 32'd0);
    for (int a = 0; a < 4096; a++) shadow[a] = 3'd1;
  endtask

  task automatic vga_check(input string name, input int x, input int y, input logic [2:0] exp);
    align(0);
    vga_x = 6'(x);
    vga_y = 6'(y);
    tick();
    tick();
    #1;
    chk(name, 32'(vga_data), 32'(exp));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b01, 2'b01, addr_of(2, 5),   12'd0,          3'd3, 3'd0, 2'b01, 1'b1, addr_of(2, 5),   3'd3};
    tbl[1]  = '{2'b10, 2'b00, 12'd0,           addr_of(2, 5),  3'd0, 3'd0, 2'b10, 1'b0, addr_of(2, 5),   3'd0};
    tbl[2]  = '{2'b11, 2'b11, addr_of(0, 0),   addr_of(7, 9),  3'd2, 3'd4, 2'b01, 1'b1, addr_of(0, 0),   3'd2};
    tbl[3]  = '{2'b11, 2'b10, addr_of(0, 0),   addr_of(7, 9),  3'd0, 3'd4, 2'b10, 1'b1, addr_of(7, 9),   3'd4};
    tbl[4]  = '{2'b11, 2'b00, addr_of(0, 0),   addr_of(7, 9),  3'd0, 3'd0, 2'b01, 1'b0, addr_of(0, 0),   3'd0};
    tbl[5]  = '{2'b11, 2'b00, addr_of(0, 0),   addr_of(7, 9),  3'd0, 3'd0, 2'b10, 1'b0, addr_of(7, 9),   3'd0};
    tbl[6]  = '{2'b01, 2'b01, addr_of(2, 40),  12'd0,          3'd5, 3'd0, 2'b01, 1'b0, addr_of(2, 40),  3'd0};
    tbl[7]  = '{2'b01, 2'b00, addr_of(2, 40),  12'd0,          3'd0, 3'd0, 2'b01, 1'b0, addr_of(2, 40),  3'd0};
    tbl[8]  = '{2'b00, 2'b00, 12'd0,           12'd0,          3'd0, 3'd0, 2'b00, 1'b0, 12'd0,           3'd0};
    tbl[9]  = '{2'b10, 2'b10, 12'd0,           addr_of(29, 39), 3'd0, 3'd7, 2'b10, 1'b1, addr_of(29, 39), 3'd7};
    tbl[10] = '{2'b10, 2'b10, 12'd0,           addr_of(30, 0), 3'd0, 3'd6, 2'b10, 1'b0, addr_of(30, 0),  3'd0};
    tbl[11] = '{2'b11, 2'b00, addr_of(29, 39), addr_of(30, 0), 3'd0, 3'd0, 2'b01, 1'b0, addr_of(29, 39), 3'd0};

    for (int a = 0; a < 4096; a++) ram[a] = 3'd0;
    rst_n = 1'b0;
    vga_x = '0; vga_y = '0;
    req_valid = 2'b11; req_we = 2'b00; req_addr = '0; req_wdata = '0;

    // Reset state with requests pending.
    repeat (3) tick();
    #1;
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_vga_data", 32'(vga_data), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;
    init_sweep();
    req_valid = 2'b00;
    mon_en = 1;

    // Both requesters held valid: grants alternate starting with bit0.
    req_we   = 2'b00;
    req_addr = {addr_of(3, 3), addr_of(1, 1)};
    req_valid = 2'b11;
    for (int g = 0; g < 3; g++) begin
      align(1);
      #1;
      chk("rr_alternate", 32'(req_ready), (g % 2 == 0) ? 32'd1 : 32'd2);
      sb.push_back('{run_cyc + 2, g % 2, shadow[(g % 2 == 0) ? addr_of(1, 1) : addr_of(3, 3)]});
      tick();
      #1;
      chk("vga_slot_no_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 2'b00;

    // Table of game-slot transactions.
    for (int i = 0; i < 12; i++) begin
      align(1);
      req_valid = tbl[i].v;
      req_we    = tbl[i].we;
      req_addr  = {tbl[i].a1, tbl[i].a0};
      req_wdata = {tbl[i].d1, tbl[i].d0};
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].mwe));
      chk($sformatf("vec%0d_mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].mwd));
      if (tbl[i].rdy != 2'b00) begin
        chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].maddr));
        if (!(tbl[i].rdy[1] ? tbl[i].we[1] : tbl[i].we[0]))
          sb.push_back('{run_cyc + 2, tbl[i].rdy[1] ? 1 : 0, shadow[tbl[i].maddr]});
      end
      if (tbl[i].mwe) shadow[tbl[i].maddr] = tbl[i].mwd;
      tick();
      req_valid = 2'b00;
    end
    repeat (4) tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);

    // VGA slot reads, including off-board coordinates.
    vga_check("vga_2_5", 5, 2, shadow[addr_of(2, 5)]);
    vga_check("vga_x45", 45, 2, 3'd0);
    vga_check("vga_x40", 40, 2, 3'd0);
    vga_check("vga_39_29", 39, 29, shadow[addr_of(29, 39)]);
    vga_check("vga_y30", 0, 30, 3'd0);
    vga_check("vga_2_5_again", 5, 2, shadow[addr_of(2, 5)]);

    // Game write followed by VGA read in the very next slot.
    align(1);
    req_valid = 2'b01; req_we = 2'b01;
    req_addr  = {12'd0, addr_of(2, 5)};
    req_wdata = {3'd0, 3'd0};
    #1;
    chk("wr_ready", 32'(req_ready), 32'd1);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    shadow[addr_of(2, 5)] = 3'd0;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    #1;
    chk("wr_then_vga", 32'(vga_data), 32'(shadow[addr_of(2, 5)]));
    chk("oob_write_ram_x40", 32'(ram[addr_of(2, 40)]), 32'd1);
    chk("oob_write_ram_y30", 32'(ram[addr_of(30, 0)]), 32'd1);

    // Reset between a read grant and its response.
    align(1);
    req_valid = 2'b01; req_we = 2'b00;
    req_addr  = {12'd0, addr_of(7, 9)};
    #1;
    chk("pre_rst_grant", 32'(req_ready), 32'd1);
    tick();
    rst_n = 1'b0;
    mon_en = 0;
    in_run = 0;
    req_valid = 2'b00;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mid_init_done", 32'(init_done), 32'd0);
      tick();
    end
    #1;
    chk("rst_mid_vga_data", 32'(vga_data), 32'd0);
    rst_n = 1'b1;
    init_sweep();
    mon_en = 1;

    // Pointer restarts favouring bit0.
    req_valid = 2'b11; req_we = 2'b00;
    req_addr  = {addr_of(7, 9), addr_of(0, 0)};
    align(1);
    #1;
    chk("post_rst_rr", 32'(req_ready), 32'd1);
    sb.push_back('{run_cyc + 2, 0, shadow[addr_of(0, 0)]});
    tick();
    req_valid = 2'b00;
    repeat (4) tick();
    chk("sb_drain_final", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/board_mem_arbiter.md
BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

Interface
REQ-001 Parameters SHALL be: X_W=6 (tile x width); Y_W=6 (tile y width); D_W=3 (tile code width); BOARD_W=40 (tiles per row); BOARD_H=30 (tile rows); INIT_TILE=3'd1 (pellet code written at init).
REQ-002 Ports SHALL be, one per line:
  clk  in  1  system clock (50 MHz)
  rst_n  in  1  reset, asynchronous, active-low
  vga_x  in  X_W  tile column requested by VGA renderer
  vga_y  in  Y_W  tile row requested by VGA renderer
  vga_data  out  D_W  registered tile code for renderer (board_data)
  req_valid  in  2  per-requester request (bit0 pac-man, bit1 ghost)
  req_we  in  2  per-requester write enable
  req_addr  in  2*(X_W+Y_W)  packed {y,x} per requester, requester i at slice i
  req_wdata  in  2*D_W  packed write data
  req_ready  out  2  one-cycle grant pulse
  rsp_valid  out  2  one-cycle read-data-valid pulse
  rsp_data  out  D_W  read data for the requester flagged in rsp_valid
  mem_addr  out  X_W+Y_W  single-port RAM address {y,x}
  mem_we  out  1  RAM write strobe
  mem_wdata  out  D_W  RAM write data
  mem_rdata  in  D_W  RAM read data, 1-cycle synchronous latency
  init_done  out  1  board initialisation complete

Function
REQ-003 The block SHALL have states INIT and RUN; INIT entered on reset, RUN entered the cycle after the init sweep writes address 4095.
REQ-004 INIT: 12-bit counter SHALL drive mem_addr 0..4095 with mem_we=1, mem_wdata=INIT_TILE, one address per cycle; req_ready=0, rsp_valid=0, vga_data=0, init_done=0.
REQ-005 RUN: 1-bit phase SHALL toggle every cycle, starting at 0 in first RUN cycle; phase 0 = VGA slot, phase 1 = game slot.
REQ-006 VGA slot SHALL drive mem_addr={vga_y,vga_x}, mem_we=0; vga_data SHALL load mem_rdata at the end of slot cycle V+1 (valid from V+2) and hold until next update.
REQ-007 If vga_x>=BOARD_W or vga_y>=BOARD_H in the VGA slot, vga_data SHALL load 0 instead of mem_rdata (flag pipelined with the read).
REQ-008 Game slot SHALL grant at most one requester: only one valid -> that one; both valid -> the one not granted last (round-robin pointer, reset value favours bit0); none -> mem_we=0, no grant.
REQ-009 Grant SHALL pulse req_ready[i] in the game-slot cycle and drive mem_addr/mem_we/mem_wdata from slice i; requester holds req_valid and payload until req_ready seen.
REQ-010 Round-robin pointer SHALL update only on a grant.
REQ-011 Granted read at cycle G SHALL produce rsp_data=mem_rdata and rsp_valid[i]=1 for exactly cycle G+2; writes produce no rsp_valid.
REQ-012 Granted write with x>=BOARD_W or y>=BOARD_H SHALL be acknowledged (req_ready) but mem_we SHALL stay 0.
REQ-013 Accesses SHALL complete in slot order: a write in game slot G is visible to a VGA read in slot G+1 and later.
REQ-014 Unused outputs SHALL be 0 in every cycle (mem_wdata=0 when mem_we=0, rsp_data=0 when no rsp_valid).

Reset
REQ-015 rst_n low SHALL asynchronously clear state to INIT, counter/phase/pointer to 0, all outputs to 0, discarding in-flight reads.
REQ-016 Reset asserted mid-RUN SHALL restart full INIT sweep after deassertion; no rsp_valid emitted for pre-reset grants.

Structure
REQ-017 Package board_pkg SHALL hold X_W, Y_W, D_W, BOARD_W, BOARD_H, tile codes (EMPTY=0, PELLET=1, WALL=3, ...) and state encoding.
REQ-018 A sub-module rr_arb2 (2-way round-robin arbiter with pointer, enable input) SHALL implement REQ-008/010.

Verification
REQ-019 Reset release, model RAM -> mem_we high 4096 cycles addresses 0..4095 data 1, then init_done=1, no req_ready during INIT.
REQ-020 RUN, vga_x=5 vga_y=2, RAM[{2,5}]=3 -> vga_data=3 two cycles after VGA slot; vga_x=45 -> vga_data=0.
REQ-021 Both req_valid held continuously, reads -> grants alternate bit0,bit1,bit0 on successive game slots; each rsp_valid exactly 2 cycles after its grant.
REQ-022 Requester 0 writes 0 to {2,5}, VGA reads {2,5} next slot -> vga_data=0; write to x=40 acked, RAM unchanged.
REQ-023 rst_n pulsed low for 3 cycles, between grant and rsp_valid of a read -> no rsp_valid, INIT sweep restarts at address 0.
